// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared types and defaults for the integer register file and
//               the load extender (load extension modes follow RV funct3).
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;

    // Load extension modes, encoded to match the RV32 load funct3 field
    typedef enum logic [2:0] {
        LB   = 3'b000,
        LH   = 3'b001,
        WORD = 3'b010,
        LBU  = 3'b100,
        LHU  = 3'b101
    } ld_mode_e;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/regfile_sb_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : load_ext
// Description : Combinational sign/zero extender for byte and halfword loads.
//               Unlisted mode codes pass the data through unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module load_ext
    import rf_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] data_i,
    input  ld_mode_e        mode_i,
    output logic [XLEN-1:0] data_o
);

    // Select the extension form from the load mode
    always_comb begin
        data_o = data_i;
        case (mode_i)
            LB:      data_o = {{(XLEN-8){data_i[7]}},   data_i[7:0]};
            LH:      data_o = {{(XLEN-16){data_i[15]}}, data_i[15:0]};
            LBU:     data_o = {{(XLEN-8){1'b0}},        data_i[7:0]};
            LHU:     data_o = {{(XLEN-16){1'b0}},       data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule : load_ext
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Integer register file with two combinational read ports, one
//               write port with load extension, same-cycle write bypass and a
//               per-register busy scoreboard for multi-cycle producers.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREG   = NREG_DEFAULT,
    parameter int AW     = $clog2(NREG),
    parameter int BYPASS = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   ra_i,
    input  logic [AW-1:0]   rb_i,
    output logic [XLEN-1:0] busa_o,
    output logic [XLEN-1:0] busb_o,
    input  logic            we_i,
    input  logic [AW-1:0]   rw_i,
    input  logic [XLEN-1:0] busw_i,
    input  logic [2:0]      ld_mode_i,
    input  logic            wb_clr_i,
    input  logic            issue_i,
    input  logic [AW-1:0]   iss_rd_i,
    output logic            busy_a_o,
    output logic            busy_b_o,
    output logic            stall_o,
    output logic [AW:0]     busy_cnt_o
);

    localparam logic [AW:0] c_cnt_one = (AW+1)'(1);

    logic [XLEN-1:0] w_ext;
    logic [XLEN-1:0] w_rdata [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic [AW:0]     r_busy_cnt;
    logic            w_set;
    logic            w_clr;
    logic            w_eff_set;
    logic            w_eff_clr;

    load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .data_i (busw_i),
        .mode_i (ld_mode_e'(ld_mode_i)),
        .data_o (w_ext)
    );

    // x0 is hardwired to zero and has no storage
    assign w_rdata[0] = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_reg
        logic [XLEN-1:0] r_q;

        // Architectural register i, loaded with the extended write data
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_q <= '0;
            end else if (we_i && (rw_i == AW'(i))) begin
                r_q <= w_ext;
            end
        end

        assign w_rdata[i] = r_q;
    end

    // Read ports: x0 reads zero, otherwise optional bypass of the in-flight write
    always_comb begin
        busa_o = w_rdata[ra_i];
        busb_o = w_rdata[rb_i];
        if ((BYPASS != 0) && we_i && (rw_i == ra_i)) busa_o = w_ext;
        if ((BYPASS != 0) && we_i && (rw_i == rb_i)) busb_o = w_ext;
        if (ra_i == '0) busa_o = '0;
        if (rb_i == '0) busb_o = '0;
    end

    // Scoreboard next state: clear first so a same-register set wins
    always_comb begin
        w_set      = issue_i && (iss_rd_i != '0);
        w_clr      = we_i && wb_clr_i;
        w_eff_set  = w_set && !r_busy[iss_rd_i];
        w_eff_clr  = w_clr && r_busy[rw_i] && !(w_set && (iss_rd_i == rw_i));
        w_busy_nxt = r_busy;
        if (w_clr) w_busy_nxt[rw_i] = 1'b0;
        if (w_set) w_busy_nxt[iss_rd_i] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Busy bits and the running count of busy registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_eff_set && !w_eff_clr) begin
                r_busy_cnt <= r_busy_cnt + c_cnt_one;
            end else if (w_eff_clr && !w_eff_set) begin
                r_busy_cnt <= r_busy_cnt - c_cnt_one;
            end
        end
    end

    // Busy reflects current state only; a same-cycle write-back does not unmask it
    assign busy_a_o   = r_busy[ra_i];
    assign busy_b_o   = r_busy[rb_i];
    assign stall_o    = busy_a_o | busy_b_o | (issue_i & r_busy[iss_rd_i]);
    assign busy_cnt_o = r_busy_cnt;

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Scoreboard bench for regfile_sb. Stimulus pushes expected
//               output values into a queue; a monitor on the falling edge
//               pops and compares them against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;
    import rf_pkg::*;

    localparam int SIG_BUSA  = 0;
    localparam int SIG_BUSB  = 1;
    localparam int SIG_BUSYA = 2;
    localparam int SIG_BUSYB = 3;
    localparam int SIG_STALL = 4;
    localparam int SIG_CNT   = 5;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra, rb, rw, iss_rd;
    logic [31:0] busa, busb, busw;
    logic        we, wb_clr, issue;
    logic [2:0]  ld_mode;
    logic        busy_a, busy_b, stall;
    logic [5:0]  busy_cnt;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ra_i       (ra),
        .rb_i       (rb),
        .busa_o     (busa),
        .busb_o     (busb),
        .we_i       (we),
        .rw_i       (rw),
        .busw_i     (busw),
        .ld_mode_i  (ld_mode),
        .wb_clr_i   (wb_clr),
        .issue_i    (issue),
        .iss_rd_i   (iss_rd),
        .busy_a_o   (busy_a),
        .busy_b_o   (busy_b),
        .stall_o    (stall),
        .busy_cnt_o (busy_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            SIG_BUSA:  return busa;
            SIG_BUSB:  return busb;
            SIG_BUSYA: return {31'b0, busy_a};
            SIG_BUSYB: return {31'b0, busy_b};
            SIG_STALL: return {31'b0, stall};
            default:   return {26'b0, busy_cnt};
        endcase
    endfunction

    // Monitor: compare every queued expectation against the settled outputs
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.sig);
            n_checks++;
            if (a !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, a, e.val);
            end
        end
    end

    task automatic exp_push(input string name, input int sig, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.val  = val;
        q.push_back(e);
    endtask

    // Advance to just after the next rising edge and return inputs to idle
    task automatic cyc();
        @(posedge clk);
        #1;
        we = 1'b0; wb_clr = 1'b0; issue = 1'b0;
        rw = '0; iss_rd = '0; ra = '0; rb = '0;
        busw = '0; ld_mode = WORD;
    endtask

    // Extension check: write x3 in one cycle (bypass on port B), read back next
    task automatic ext_case(input string name, input logic [2:0] mode,
                            input logic [31:0] data, input logic [31:0] exp_v);
        cyc();
        we = 1'b1; rw = 5'd3; busw = data; ld_mode = mode; rb = 5'd3;
        exp_push({name, "_bypass"}, SIG_BUSB, exp_v);
        cyc();
        ra = 5'd3;
        exp_push({name, "_stored"}, SIG_BUSA, exp_v);
    endtask

    initial begin
        rst = 1'b1;
        we = 1'b0; wb_clr = 1'b0; issue = 1'b0;
        rw = '0; iss_rd = '0; ra = '0; rb = '0; busw = '0; ld_mode = WORD;

        // Reset state on every address
        for (int i = 0; i < 32; i++) begin
            cyc();
            ra = 5'(i); rb = 5'(31 - i);
            exp_push("rst_busa", SIG_BUSA, 32'h0);
            exp_push("rst_busb", SIG_BUSB, 32'h0);
        end
        exp_push("rst_cnt", SIG_CNT, 32'h0);
        exp_push("rst_stall", SIG_STALL, 32'h0);
        cyc();
        rst = 1'b0;

        // Write x5 then assert reset asynchronously
        cyc();
        we = 1'b1; rw = 5'd5; busw = 32'h0000_1234; ra = 5'd5;
        exp_push("x5_bypass", SIG_BUSA, 32'h0000_1234);
        cyc();
        ra = 5'd5;
        exp_push("x5_stored", SIG_BUSA, 32'h0000_1234);
        cyc();
        ra = 5'd5; rst = 1'b1;
        exp_push("x5_async_rst", SIG_BUSA, 32'h0);
        cyc();
        rst = 1'b0;

        // Load extension
        ext_case("lb",   LB,     32'h0000_80F0, 32'hFFFF_FFF0);
        ext_case("lbu",  LBU,    32'h0000_80F0, 32'h0000_00F0);
        ext_case("lh",   LH,     32'h0000_80F0, 32'hFFFF_80F0);
        ext_case("lhu",  LHU,    32'h0000_80F0, 32'h0000_80F0);
        ext_case("word", WORD,   32'h0000_80F0, 32'h0000_80F0);
        ext_case("mode7", 3'b111, 32'h1234_5678, 32'h1234_5678);

        // Writes to x0 are ignored
        cyc();
        we = 1'b1; rw = 5'd0; busw = 32'hDEAD_BEEF;
        exp_push("x0_same_a", SIG_BUSA, 32'h0);
        exp_push("x0_same_b", SIG_BUSB, 32'h0);
        cyc();
        exp_push("x0_next", SIG_BUSA, 32'h0);

        // Same-cycle bypass on both ports
        cyc();
        we = 1'b1; rw = 5'd7; busw = 32'hA5A5_A5A5; ra = 5'd7; rb = 5'd7;
        exp_push("byp_a", SIG_BUSA, 32'hA5A5_A5A5);
        exp_push("byp_b", SIG_BUSB, 32'hA5A5_A5A5);
        cyc();
        ra = 5'd7; rb = 5'd7;
        exp_push("byp_a_next", SIG_BUSA, 32'hA5A5_A5A5);
        exp_push("byp_b_next", SIG_BUSB, 32'hA5A5_A5A5);

        // Scoreboard: issue and write-back x9
        cyc();
        issue = 1'b1; iss_rd = 5'd9; ra = 5'd9;
        exp_push("iss9_busy_a", SIG_BUSYA, 32'h0);
        exp_push("iss9_stall", SIG_STALL, 32'h0);
        cyc();
        ra = 5'd9;
        exp_push("x9_busy_a", SIG_BUSYA, 32'h1);
        exp_push("x9_stall", SIG_STALL, 32'h1);
        exp_push("x9_cnt", SIG_CNT, 32'h1);
        cyc();
        we = 1'b1; wb_clr = 1'b1; rw = 5'd9; busw = 32'h55; ra = 5'd9;
        exp_push("wb9_stall", SIG_STALL, 32'h1);
        exp_push("wb9_busy_a", SIG_BUSYA, 32'h1);
        exp_push("wb9_busa", SIG_BUSA, 32'h55);
        cyc();
        ra = 5'd9;
        exp_push("post9_busy_a", SIG_BUSYA, 32'h0);
        exp_push("post9_stall", SIG_STALL, 32'h0);
        exp_push("post9_cnt", SIG_CNT, 32'h0);

        // Simultaneous set and clear of x4: set wins
        cyc();
        issue = 1'b1; iss_rd = 5'd4;
        cyc();
        rb = 5'd4;
        exp_push("x4_busy_b", SIG_BUSYB, 32'h1);
        exp_push("x4_cnt", SIG_CNT, 32'h1);
        cyc();
        issue = 1'b1; iss_rd = 5'd4; we = 1'b1; wb_clr = 1'b1; rw = 5'd4; busw = 32'h7;
        exp_push("x4_reissue_stall", SIG_STALL, 32'h1);
        cyc();
        rb = 5'd4;
        exp_push("x4_still_busy", SIG_BUSYB, 32'h1);
        exp_push("x4_cnt_same", SIG_CNT, 32'h1);
        exp_push("x4_data", SIG_BUSB, 32'h7);

        // Issue to x0 is ignored
        cyc();
        issue = 1'b1; iss_rd = 5'd0;
        exp_push("iss0_stall", SIG_STALL, 32'h0);
        cyc();
        ra = 5'd0;
        exp_push("iss0_cnt", SIG_CNT, 32'h1);
        exp_push("iss0_busy_a", SIG_BUSYA, 32'h0);

        // Set x6 while clearing x4: count unchanged, bits move
        cyc();
        issue = 1'b1; iss_rd = 5'd6; we = 1'b1; wb_clr = 1'b1; rw = 5'd4; busw = 32'h8;
        cyc();
        ra = 5'd6; rb = 5'd4;
        exp_push("swap_busy6", SIG_BUSYA, 32'h1);
        exp_push("swap_busy4", SIG_BUSYB, 32'h0);
        exp_push("swap_cnt", SIG_CNT, 32'h1);

        // Clear of a non-busy register has no effect
        cyc();
        we = 1'b1; wb_clr = 1'b1; rw = 5'd10; busw = 32'h1;
        cyc();
        exp_push("clr_idle_cnt", SIG_CNT, 32'h1);

        // Re-issue to busy x6 is flagged and does not change the count
        cyc();
        issue = 1'b1; iss_rd = 5'd6;
        exp_push("reiss6_stall", SIG_STALL, 32'h1);
        cyc();
        ra = 5'd6;
        exp_push("reiss6_cnt", SIG_CNT, 32'h1);
        exp_push("reiss6_busy", SIG_BUSYA, 32'h1);

        // Final write-back of x6 empties the scoreboard
        cyc();
        we = 1'b1; wb_clr = 1'b1; rw = 5'd6; busw = 32'h2;
        cyc();
        ra = 5'd6;
        exp_push("final_cnt", SIG_CNT, 32'h0);
        exp_push("final_busy", SIG_BUSYA, 32'h0);

        cyc();
        cyc();
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_sb
`default_nettype wire
